// File: rtl/prco_decode_pkg.sv
// Shared constants for the PRCO decode stage: opcodes, ALU codes, register indices
// and the control word produced by the opcode decoder.
package prco_decode_pkg;

   localparam logic [4:0] OP_NOP  = 5'h00;
   localparam logic [4:0] OP_MOV  = 5'h01;
   localparam logic [4:0] OP_MOVI = 5'h02;
   localparam logic [4:0] OP_ADD  = 5'h03;
   localparam logic [4:0] OP_SUB  = 5'h04;
   localparam logic [4:0] OP_CMP  = 5'h05;
   localparam logic [4:0] OP_ADDI = 5'h06;
   localparam logic [4:0] OP_PUSH = 5'h07;
   localparam logic [4:0] OP_POP  = 5'h08;
   localparam logic [4:0] OP_HALT = 5'h1F;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_PASSB = 2'd2;
   localparam logic [1:0] ALU_CMP   = 2'd3;

   localparam logic [2:0] REG_SP = 3'd6;
   localparam logic [2:0] REG_BP = 3'd7;

   typedef enum logic [1:0] {OpbDatb, OpbZext, OpbSext, OpbOne} opb_src_e;

   typedef struct packed {
      logic       legal;
      logic       two_uop;
      logic [2:0] sela;
      logic [2:0] selb;
      logic [1:0] alu_op;
      logic       wb_en;
      logic [2:0] wb_sel;
      logic       mem_we;
      logic       mem_re;
      opb_src_e   opb_src;
   } ctl_t;

endpackage

// File: rtl/prco_decode_ctl.sv
// Combinational opcode decoder: maps opcode, register fields and micro-op step
// to read selects, ALU/write-back/memory controls and the operand-B source.
module prco_decode_ctl
   import prco_decode_pkg::*;
(
   input  logic [4:0] op,
   input  logic [2:0] rd,
   input  logic [2:0] ra,
   input  logic [2:0] rb,
   input  logic       step,
   output ctl_t       ctl
);

   always_comb begin
      ctl         = '0;
      ctl.legal   = 1'b1;
      ctl.sela    = ra;
      ctl.selb    = rb;
      ctl.wb_sel  = rd;
      ctl.alu_op  = ALU_ADD;
      ctl.opb_src = OpbDatb;
      case (op)
         OP_MOV: begin
            ctl.alu_op = ALU_PASSB;
            ctl.wb_en  = 1'b1;
         end
         OP_MOVI: begin
            ctl.alu_op  = ALU_PASSB;
            ctl.opb_src = OpbZext;
            ctl.wb_en   = 1'b1;
         end
         OP_ADD: ctl.wb_en = 1'b1;
         OP_SUB: begin
            ctl.alu_op = ALU_SUB;
            ctl.wb_en  = 1'b1;
         end
         OP_CMP: ctl.alu_op = ALU_SUB;
         OP_ADDI: begin
            ctl.sela    = rd;
            ctl.opb_src = OpbSext;
            ctl.wb_en   = 1'b1;
         end
         // Step 0 pre-decrements SP; step 1 stores rb at the new SP
         OP_PUSH: begin
            ctl.two_uop = 1'b1;
            ctl.sela    = REG_SP;
            if (!step) begin
               ctl.alu_op  = ALU_SUB;
               ctl.opb_src = OpbOne;
               ctl.wb_en   = 1'b1;
               ctl.wb_sel  = REG_SP;
            end else begin
               ctl.mem_we = 1'b1;
            end
         end
         OP_POP: begin
            ctl.two_uop = 1'b1;
            ctl.sela    = REG_SP;
            if (!step) begin
               ctl.mem_re = 1'b1;
               ctl.wb_en  = 1'b1;
            end else begin
               ctl.opb_src = OpbOne;
               ctl.wb_en   = 1'b1;
               ctl.wb_sel  = REG_SP;
            end
         end
         default: ctl.legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/prco_decode.sv
// PRCO decode/operand-fetch stage: accepts an instruction, drives register-file
// selects, captures operands after the read latency and issues micro-ops.
module prco_decode
   import prco_decode_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_en,
   input  logic        i_instr_valid,
   input  logic [15:0] i_instr,
   output logic        q_instr_ready,
   output logic [2:0]  q_sela,
   output logic [2:0]  q_selb,
   input  logic [15:0] i_data,
   input  logic [15:0] i_datb,
   output logic        q_uop_valid,
   input  logic        i_uop_ready,
   output logic [1:0]  q_alu_op,
   output logic [15:0] q_opa,
   output logic [15:0] q_opb,
   output logic        q_wb_en,
   output logic [2:0]  q_wb_sel,
   output logic        q_mem_we,
   output logic        q_mem_re,
   output logic        q_halt,
   output logic        q_illegal
);

   typedef enum logic [2:0] {StIdle, StRead, StCapt, StIssue, StSeq2, StHalt} state_e;

   state_e      state_q, state_d;
   logic [15:0] instr_q;
   logic        step_q;
   logic [15:0] dec_instr;
   logic [15:0] opb_val;
   logic [4:0]  dec_op;
   ctl_t        ctl;

   // In IDLE decode the instruction being offered, otherwise the latched one
   assign dec_instr = (state_q == StIdle) ? i_instr : instr_q;
   assign dec_op    = dec_instr[15:11];

   prco_decode_ctl u_ctl (
      .op   (dec_op),
      .rd   (dec_instr[10:8]),
      .ra   (dec_instr[7:5]),
      .rb   (dec_instr[4:2]),
      .step (step_q),
      .ctl  (ctl)
   );

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) state_q <= StIdle;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (i_en) begin
         unique case (state_q)
            StIdle: begin
               if (i_instr_valid) begin
                  if (dec_op == OP_HALT)   state_d = StHalt;
                  else if (ctl.legal)      state_d = StRead;
               end
            end
            StRead:  state_d = StCapt;
            StCapt:  state_d = StIssue;
            StIssue: begin
               if (i_uop_ready) state_d = (ctl.two_uop && !step_q) ? StSeq2 : StIdle;
            end
            StSeq2:  state_d = StRead;
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      q_instr_ready = (state_q == StIdle) && i_reset_n;
   end

   always_comb begin
      opb_val = i_datb;
      unique case (ctl.opb_src)
         OpbDatb: opb_val = i_datb;
         OpbZext: opb_val = {8'h00, instr_q[7:0]};
         OpbSext: opb_val = {{8{instr_q[7]}}, instr_q[7:0]};
         OpbOne:  opb_val = 16'h0001;
         default: opb_val = i_datb;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         instr_q     <= 16'h0;
         step_q      <= 1'b0;
         q_sela      <= 3'd0;
         q_selb      <= 3'd0;
         q_uop_valid <= 1'b0;
         q_alu_op    <= 2'd0;
         q_opa       <= 16'h0;
         q_opb       <= 16'h0;
         q_wb_en     <= 1'b0;
         q_wb_sel    <= 3'd0;
         q_mem_we    <= 1'b0;
         q_mem_re    <= 1'b0;
         q_halt      <= 1'b0;
         q_illegal   <= 1'b0;
      end else if (i_en) begin
         q_illegal <= 1'b0;
         case (state_q)
            StIdle: begin
               if (i_instr_valid) begin
                  instr_q   <= i_instr;
                  q_sela    <= ctl.sela;
                  q_selb    <= ctl.selb;
                  q_illegal <= (dec_op != OP_NOP) && (dec_op != OP_HALT) && !ctl.legal;
                  if (dec_op == OP_HALT) q_halt <= 1'b1;
               end
            end
            StCapt: begin
               q_opa       <= i_data;
               q_opb       <= opb_val;
               q_alu_op    <= ctl.alu_op;
               q_wb_en     <= ctl.wb_en;
               q_wb_sel    <= ctl.wb_sel;
               q_mem_we    <= ctl.mem_we;
               q_mem_re    <= ctl.mem_re;
               q_uop_valid <= 1'b1;
            end
            StIssue: begin
               if (i_uop_ready) begin
                  q_uop_valid <= 1'b0;
                  step_q      <= ctl.two_uop && !step_q;
               end
            end
            StSeq2: begin
               q_sela <= ctl.sela;
               q_selb <= ctl.selb;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prco_decode.sv
// Self-checking bench for prco_decode: register-file/memory/execute model in the
// bench, directed scenarios plus randomized instruction streams.
module tb_prco_decode;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic [2:0]  sela, selb;
   logic [15:0] data_a, data_b;
   logic        uop_valid;
   logic        uop_ready;
   logic [1:0]  alu_op;
   logic [15:0] opa, opb;
   logic        wb_en;
   logic [2:0]  wb_sel;
   logic        mem_we, mem_re, halt, illegal;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;

   logic [15:0] rf [8];
   logic [15:0] mem [logic [15:0]];

   typedef struct {
      logic [1:0]  alu;
      logic [15:0] opa;
      logic [15:0] opb;
      logic        wb_en;
      logic [2:0]  wb_sel;
      logic        we;
      logic        re;
      logic        c_alu;
      logic        c_opa;
      logic        c_opb;
      logic        c_wbsel;
   } uop_t;

   prco_decode dut (
      .i_clk         (clk),
      .i_reset_n     (rst_n),
      .i_en          (en),
      .i_instr_valid (instr_valid),
      .i_instr       (instr),
      .q_instr_ready (instr_ready),
      .q_sela        (sela),
      .q_selb        (selb),
      .i_data        (data_a),
      .i_datb        (data_b),
      .q_uop_valid   (uop_valid),
      .i_uop_ready   (uop_ready),
      .q_alu_op      (alu_op),
      .q_opa         (opa),
      .q_opb         (opb),
      .q_wb_en       (wb_en),
      .q_wb_sel      (wb_sel),
      .q_mem_we      (mem_we),
      .q_mem_re      (mem_re),
      .q_halt        (halt),
      .q_illegal     (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file with one cycle of read latency
   always @(posedge clk) begin
      data_a <= rf[sela];
      data_b <= rf[selb];
      cyc    <= cyc + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected micro-op straight from the instruction table and current register contents
   function automatic uop_t model(input logic [15:0] ins, input int step);
      uop_t u;
      int   op, rd, ra, rb, imm, simm;
      op = int'(ins[15:11]);
      rd = int'(ins[10:8]);
      ra = int'(ins[7:5]);
      rb = int'(ins[4:2]);
      imm = int'(ins[7:0]);
      simm = (imm >= 128) ? imm - 256 : imm;
      u.alu = 2'd0; u.opa = rf[ra]; u.opb = rf[rb]; u.wb_en = 1'b1; u.wb_sel = 3'(rd);
      u.we = 1'b0; u.re = 1'b0;
      u.c_alu = 1'b1; u.c_opa = 1'b1; u.c_opb = 1'b1; u.c_wbsel = 1'b1;
      case (op)
         1: begin u.alu = 2'd2; u.c_opa = 1'b0; end
         2: begin u.alu = 2'd2; u.opb = 16'(imm); u.c_opa = 1'b0; end
         3: u.alu = 2'd0;
         4: u.alu = 2'd1;
         5: begin u.alu = 2'd1; u.wb_en = 1'b0; u.c_wbsel = 1'b0; end
         6: begin u.opa = rf[rd]; u.opb = 16'(simm); end
         7: begin
            u.opa = rf[6];
            if (step == 0) begin
               u.alu = 2'd1; u.opb = 16'd1; u.wb_sel = 3'd6;
            end else begin
               u.wb_en = 1'b0; u.we = 1'b1; u.c_alu = 1'b0; u.c_wbsel = 1'b0;
            end
         end
         8: begin
            u.opa = rf[6];
            if (step == 0) begin
               u.re = 1'b1; u.c_alu = 1'b0; u.c_opb = 1'b0;
            end else begin
               u.alu = 2'd0; u.opb = 16'd1; u.wb_sel = 3'd6;
            end
         end
         default: ;
      endcase
      return u;
   endfunction

   // Execute stage: result lands in the register file on the accept edge
   task automatic execute(input uop_t u);
      logic [15:0] r;
      if (u.re) r = mem.exists(u.opa) ? mem[u.opa] : (u.opa ^ 16'hA5A5);
      else if (u.alu == 2'd0) r = u.opa + u.opb;
      else if (u.alu == 2'd1) r = u.opa - u.opb;
      else r = u.opb;
      if (u.we) mem[u.opa] = u.opb;
      if (u.wb_en) rf[u.wb_sel] = r;
   endtask

   function automatic logic [39:0] pack_dut();
      return {alu_op, opa, opb, wb_en, wb_sel, mem_we, mem_re};
   endfunction

   function automatic logic [39:0] pack_exp(input uop_t u);
      return {u.alu, u.opa, u.opb, u.wb_en, u.wb_sel, u.we, u.re};
   endfunction

   function automatic logic [39:0] mask_of(input uop_t u);
      return {{2{u.c_alu}}, {16{u.c_opa}}, {16{u.c_opb}}, 1'b1, {3{u.c_wbsel}}, 2'b11};
   endfunction

   task automatic accept_instr(input logic [15:0] ins);
      n_total++;
      if (instr_ready !== 1'b1)
         $display("FAIL accept_ready ins=%h: got %b want 1", ins, instr_ready);
      else n_pass++;
      instr = ins;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      instr = 16'($urandom);
   endtask

   // Waits for each micro-op, checks latency, fields, stability under stall and handshake
   task automatic finish_instr(input logic [15:0] ins, input int stall);
      uop_t        u;
      int          cnt, nu;
      logic [39:0] want, m;
      nu = (ins[15:11] == 5'h07 || ins[15:11] == 5'h08) ? 2 : 1;
      for (int s = 0; s < nu; s++) begin
         u = model(ins, s);
         want = pack_exp(u);
         m = mask_of(u);
         cnt = 0;
         while (uop_valid !== 1'b1 && cnt < 8) begin
            tick();
            cnt++;
         end
         n_total++;
         if (cnt != ((s == 0) ? 2 : 3))
            $display("FAIL uop_latency ins=%h step=%0d: got %0d want %0d", ins, s, cnt,
                     (s == 0) ? 2 : 3);
         else n_pass++;
         n_total++;
         if ((pack_dut() & m) !== (want & m))
            $display("FAIL uop_fields ins=%h step=%0d: got %h want %h", ins, s,
                     pack_dut() & m, want & m);
         else n_pass++;
         for (int k = 0; k < stall; k++) begin
            tick();
            n_total++;
            if ({uop_valid, instr_ready, pack_dut() & m} !== {1'b1, 1'b0, want & m})
               $display("FAIL uop_stall ins=%h cyc=%0d: got %b/%b/%h want 1/0/%h", ins, k,
                        uop_valid, instr_ready, pack_dut() & m, want & m);
            else n_pass++;
         end
         uop_ready = 1'b1;
         tick();
         uop_ready = 1'b0;
         n_total++;
         if ({uop_valid, instr_ready} !== {1'b0, (s == nu - 1)})
            $display("FAIL uop_handshake ins=%h step=%0d: got valid=%b ready=%b want 0/%b",
                     ins, s, uop_valid, instr_ready, (s == nu - 1));
         else n_pass++;
         execute(u);
      end
   endtask

   task automatic run_instr(input logic [15:0] ins, input int stall);
      accept_instr(ins);
      if (ins[15:11] == 5'h00) begin
         n_total++;
         if ({instr_ready, uop_valid} !== 2'b10)
            $display("FAIL nop ins=%h: got ready=%b valid=%b want 1/0", ins, instr_ready,
                     uop_valid);
         else n_pass++;
      end else begin
         finish_instr(ins, stall);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; instr_valid = 1'b1; instr = 16'h1800; uop_ready = 1'b0;
      tick();
      tick();
      n_total++;
      if ({uop_valid, halt, illegal, wb_en, mem_we, mem_re, opa, opb, sela, selb, wb_sel,
           alu_op, instr_ready} !== 56'h0)
         $display("FAIL reset_values: got valid=%b halt=%b ill=%b opa=%h opb=%h ready=%b want 0",
                  uop_valid, halt, illegal, opa, opb, instr_ready);
      else n_pass++;
      instr_valid = 1'b0;
      rst_n = 1'b1;
      tick();
      n_total++;
      if (instr_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", instr_ready);
      else n_pass++;
   endtask

   task automatic test_add();
      rf[1] = 16'd5; rf[2] = 16'd7;
      run_instr({5'h03, 3'd3, 3'd1, 3'd2, 2'b00}, 0);
      n_total++;
      if (rf[3] !== 16'd12) $display("FAIL add_result: got %h want 000c", rf[3]);
      else n_pass++;
   endtask

   task automatic test_addi_stall();
      rf[0] = 16'h0010;
      run_instr({5'h06, 3'd0, 8'hFE}, 3);
   endtask

   task automatic test_push_pop();
      rf[6] = 16'h00FF; rf[2] = 16'hBEEF;
      run_instr({5'h07, 3'd0, 3'd0, 3'd2, 2'b00}, 1);
      run_instr({5'h08, 3'd4, 8'h00}, 0);
      n_total++;
      if ({rf[4], rf[6]} !== {16'hBEEF, 16'h00FF})
         $display("FAIL push_pop_roundtrip: got %h/%h want beef/00ff", rf[4], rf[6]);
      else n_pass++;
   endtask

   task automatic test_sp_wrap();
      rf[6] = 16'h0000; rf[5] = 16'h1234;
      run_instr({5'h07, 3'd0, 3'd0, 3'd5, 2'b00}, 0);
      n_total++;
      if (rf[6] !== 16'hFFFF) $display("FAIL sp_wrap: got %h want ffff", rf[6]);
      else n_pass++;
   endtask

   task automatic test_illegal();
      logic [15:0] mov;
      mov = {5'h01, 3'd2, 3'd0, 3'd7, 2'b00};
      accept_instr({5'h15, 11'h2A5});
      n_total++;
      if ({illegal, uop_valid, instr_ready} !== 3'b101)
         $display("FAIL illegal_pulse: got ill=%b valid=%b ready=%b want 1/0/1", illegal,
                  uop_valid, instr_ready);
      else n_pass++;
      accept_instr(mov);
      n_total++;
      if ({illegal, instr_ready} !== 2'b00)
         $display("FAIL illegal_clear: got ill=%b ready=%b want 0/0", illegal, instr_ready);
      else n_pass++;
      finish_instr(mov, 0);
   endtask

   task automatic test_enable();
      logic [15:0] ins;
      uop_t        u;
      accept_instr({5'h1A, 11'h000});
      en = 1'b0;
      tick();
      tick();
      n_total++;
      if ({illegal, instr_ready} !== 2'b11)
         $display("FAIL en_hold_illegal: got ill=%b ready=%b want 1/1", illegal, instr_ready);
      else n_pass++;
      en = 1'b1;
      tick();
      n_total++;
      if (illegal !== 1'b0) $display("FAIL en_illegal_drop: got %b want 0", illegal);
      else n_pass++;
      rf[1] = 16'h7FFF; rf[4] = 16'h0002;
      ins = {5'h04, 3'd5, 3'd1, 3'd4, 2'b00};
      accept_instr(ins);
      u = model(ins, 0);
      tick();
      tick();
      en = 1'b0;
      uop_ready = 1'b1;
      tick();
      n_total++;
      if ({uop_valid, pack_dut() & mask_of(u)} !== {1'b1, pack_exp(u) & mask_of(u)})
         $display("FAIL en_block_handshake: got %b/%h want 1/%h", uop_valid,
                  pack_dut() & mask_of(u), pack_exp(u) & mask_of(u));
      else n_pass++;
      en = 1'b1;
      tick();
      uop_ready = 1'b0;
      n_total++;
      if ({uop_valid, instr_ready} !== 2'b01)
         $display("FAIL en_resume_handshake: got %b/%b want 0/1", uop_valid, instr_ready);
      else n_pass++;
      execute(u);
   endtask

   task automatic test_back_to_back();
      int t0;
      for (int i = 0; i < 4; i++) rf[i] = 16'(i * 3 + 1);
      t0 = cyc;
      run_instr({5'h03, 3'd0, 3'd1, 3'd2, 2'b00}, 0);
      run_instr({5'h04, 3'd1, 3'd3, 3'd0, 2'b00}, 0);
      run_instr({5'h05, 3'd2, 3'd1, 3'd0, 2'b00}, 0);
      n_total++;
      if (cyc - t0 != 12) $display("FAIL back_to_back_cycles: got %0d want 12", cyc - t0);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [15:0] ins;
      for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
      for (int n = 0; n < 40; n++) begin
         ins = {5'($urandom_range(0, 8)), 11'($urandom)};
         run_instr(ins, $urandom_range(0, 2));
      end
   endtask

   task automatic test_reset_seq2();
      logic [15:0] ins;
      uop_t        u;
      logic        bad;
      rf[6] = 16'h0040; rf[3] = 16'h1234;
      ins = {5'h07, 3'd0, 3'd0, 3'd3, 2'b00};
      accept_instr(ins);
      u = model(ins, 0);
      tick();
      tick();
      uop_ready = 1'b1;
      tick();
      uop_ready = 1'b0;
      execute(u);
      rst_n = 1'b0;
      tick();
      n_total++;
      if ({uop_valid, halt, illegal, wb_en, mem_we, mem_re, opa, opb, sela, selb, wb_sel,
           alu_op} !== 55'h0)
         $display("FAIL seq2_reset_values: got valid=%b opa=%h opb=%h we=%b want 0",
                  uop_valid, opa, opb, mem_we);
      else n_pass++;
      rst_n = 1'b1;
      bad = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (uop_valid !== 1'b0 || instr_ready !== 1'b1) bad = 1'b1;
      end
      n_total++;
      if (bad) $display("FAIL seq2_no_uop2: got stray uop or not ready want idle");
      else n_pass++;
   endtask

   task automatic test_halt();
      logic bad;
      accept_instr({5'h1F, 11'h000});
      n_total++;
      if ({halt, instr_ready, uop_valid} !== 3'b100)
         $display("FAIL halt_enter: got halt=%b ready=%b valid=%b want 1/0/0", halt,
                  instr_ready, uop_valid);
      else n_pass++;
      instr = {5'h03, 3'd1, 3'd1, 3'd1, 2'b00};
      instr_valid = 1'b1;
      bad = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (halt !== 1'b1 || instr_ready !== 1'b0 || uop_valid !== 1'b0) bad = 1'b1;
      end
      n_total++;
      if (bad) $display("FAIL halt_sticky: got exit from halt want halted");
      else n_pass++;
      instr_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      n_total++;
      if ({halt, instr_ready} !== 2'b01)
         $display("FAIL halt_reset: got halt=%b ready=%b want 0/1", halt, instr_ready);
      else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) rf[i] = 16'h0;
      test_reset();
      test_add();
      test_addi_stall();
      test_push_pop();
      test_sp_wrap();
      test_illegal();
      test_enable();
      test_back_to_back();
      test_random();
      test_reset_seq2();
      test_halt();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
